// File: rtl/chip8_fetch.sv
`timescale 1ns/1ps
// CHIP-8 fetch stage: reads a byte-wide sync ROM, assembles big-endian opcodes into a FIFO.
// Optional starvation counter is built only when CHIP8_FETCH_STALL_CNT_EN is defined.
module chip8_fetch #(
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       op;
  } entry_t;

  typedef enum logic {S_HI, S_LO} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc, pend_pc;
  logic [7:0]        hi_byte;
  logic              lo_pending;

  entry_t            fifo_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic              pop, push, issue;
  logic [OW-1:0]     occ;

  // The lo byte landing this cycle is already committed to a slot, so it counts as occupancy.
  always_comb begin
    instr_valid = (count != '0);
    pop         = instr_valid & instr_ready;
    push        = (state_q == S_HI) & lo_pending;
    occ         = {1'b0, count} + OW'(lo_pending) - OW'(pop);
    issue       = (state_q == S_HI) && (occ < OW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) state_q <= S_HI;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HI: if (issue) state_d = S_LO;
      S_LO: state_d = S_HI;
    endcase
  end

  // fetch_pc has already advanced past the pending opcode when the S_HI read goes out.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = (state_q == S_LO) ? fetch_pc + ADDR_W'(1) : fetch_pc;
    if (!rst) mem_rd_en = (state_q == S_LO) | issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      hi_byte    <= '0;
      lo_pending <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      lo_pending <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (state_q == S_LO) begin
        hi_byte    <= mem_rdata;
        pend_pc    <= fetch_pc;
        fetch_pc   <= fetch_pc + ADDR_W'(2);
        lo_pending <= 1'b1;
      end else if (push) begin
        lo_pending <= 1'b0;
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: pend_pc, op: {hi_byte, mem_rdata}};
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign instr    = fifo_q[rd_ptr].op;
  assign instr_pc = fifo_q[rd_ptr].pc;

`ifdef CHIP8_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)                                                   stall_q <= '0;
    else if (instr_ready && !instr_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
